// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - request size encodings (SZ_WORD / SZ_HALF / SZ_BYTE; 2'b11 behaves as byte)
//   - FSM state enum
//   - needs_split(): does an access straddle a 32-bit word boundary
//   - size_mask():   LSB-aligned lane mask for an access size
package lsu_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_DONE  = 3'd5
    } lsu_state_e;

    // A word splits at any non-zero offset, a half only at offset 3.
    function automatic logic needs_split(input logic [1:0] size, input logic [1:0] off);
        logic split;
        case (size)
            SZ_WORD: split = (off != 2'b00);
            SZ_HALF: split = (off == 2'b11);
            default: split = 1'b0;
        endcase
        return split;
    endfunction

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] mask;
        case (size)
            SZ_WORD: mask = 4'b1111;
            SZ_HALF: mask = 4'b0011;
            default: mask = 4'b0001;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: purely combinational lane steering for the LSU.
// Store side (driven from the incoming request):
//   st_size, st_off, st_wdata  -> be0/wd0 for the first word, be1/wd1 for the
//                                 second word of a split access
// Load side (driven from the registered request and the read words):
//   ld_size, ld_off, ld_sign, ld_lo, ld_hi -> ld_data, LSB-aligned and extended
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic [31:0] wd0,
    output logic [31:0] wd1,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_sign,
    input  logic [31:0] ld_lo,
    input  logic [31:0] ld_hi,
    output logic [31:0] ld_data
);

    logic [7:0]  lanes_s;
    logic [63:0] wide_s;
    logic [31:0] raw_s;

    // Store lanes: shift the mask/data across a two-word window; the upper
    // half of the window is whatever spills into the following word.
    always_comb begin
        lanes_s = {4'h0, size_mask(st_size)} << st_off;
        wide_s  = {32'h0, st_wdata} << {st_off, 3'b000};
        be0     = lanes_s[3:0];
        be1     = lanes_s[7:4];
        wd0     = wide_s[31:0];
        wd1     = wide_s[63:32];
    end

    // Load extract: ld_hi holds the second word of a split (zero otherwise).
    always_comb begin
        raw_s = 32'({ld_hi, ld_lo} >> {ld_off, 3'b000});
        case (ld_size)
            SZ_WORD: ld_data = raw_s;
            SZ_HALF: ld_data = {{16{ld_sign & raw_s[15]}}, raw_s[15:0]};
            default: ld_data = {{24{ld_sign & raw_s[7]}}, raw_s[7:0]};
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: CPU-side initiator for the byte-addressed data memory.
// Accepts one load/store at a time (req_valid/req_ready), issues word-aligned
// byte-enabled transactions (mem_req/mem_gnt, mem_rvalid), splits accesses
// that cross a word boundary into two transactions and returns extended load
// data with a one-cycle resp_valid pulse.
// Ports: clk, rst_n (async active-low); request req_*; response resp_*;
//        memory side mem_* (mem_addr is ADDR_W bits, always word aligned).
// Build option: LSU_MISALIGN_TRAP_EN - split-class requests are not issued
// to memory and complete next cycle with resp_err=1 and resp_rdata=0.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        state_r;
    logic              we_r;
    logic [1:0]        size_r;
    logic              sign_r;
    logic [1:0]        off_r;
    logic              split_r;
    logic [ADDR_W-1:0] addr1_r;
    logic [3:0]        be1_r;
    logic [31:0]       wd1_r;
    logic [31:0]       lo_r;

    logic              accept_s;
    logic              split_in_s;
    logic [ADDR_W-1:0] addr0_s;
    logic [ADDR_W-1:0] addr1_s;
    logic [3:0]        be0_s;
    logic [3:0]        be1_s;
    logic [31:0]       wd0_s;
    logic [31:0]       wd1_s;
    logic [31:0]       ld_lo_s;
    logic [31:0]       ld_hi_s;
    logic [31:0]       ld_data_s;
    logic              unused_addr_s;

    assign accept_s      = req_valid && req_ready;
    assign split_in_s    = needs_split(req_size, req_addr[1:0]);
    assign addr0_s       = {req_addr[ADDR_W-1:2], 2'b00};
    assign addr1_s       = addr0_s + ADDR_W'(3'd4);  // wraps at the top of memory
    assign unused_addr_s = ^req_addr[31:ADDR_W];

    lsu_lane_align u_align (
        .st_size  (req_size),
        .st_off   (req_addr[1:0]),
        .st_wdata (req_wdata),
        .be0      (be0_s),
        .be1      (be1_s),
        .wd0      (wd0_s),
        .wd1      (wd1_s),
        .ld_size  (size_r),
        .ld_off   (off_r),
        .ld_sign  (sign_r),
        .ld_lo    (ld_lo_s),
        .ld_hi    (ld_hi_s),
        .ld_data  (ld_data_s)
    );

    // Extraction window: in WAIT1 merge the saved first word with the second.
    always_comb begin
        ld_lo_s = mem_rdata;
        ld_hi_s = 32'h0;
        if (state_r == ST_WAIT1) begin
            ld_lo_s = lo_r;
            ld_hi_s = mem_rdata;
        end else begin
            ld_lo_s = mem_rdata;
            ld_hi_s = 32'h0;
        end
    end

    // Access sequencer with registered request/response and memory outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            we_r       <= 1'b0;
            size_r     <= 2'b00;
            sign_r     <= 1'b0;
            off_r      <= 2'b00;
            split_r    <= 1'b0;
            addr1_r    <= '0;
            be1_r      <= 4'h0;
            wd1_r      <= 32'h0;
            lo_r       <= 32'h0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= 4'h0;
            mem_wdata  <= 32'h0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        we_r      <= req_we;
                        size_r    <= req_size;
                        sign_r    <= req_sign;
                        off_r     <= req_addr[1:0];
                        split_r   <= split_in_s;
                        addr1_r   <= addr1_s;
                        be1_r     <= be1_s;
                        wd1_r     <= req_we ? wd1_s : 32'h0;
                        req_ready <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (split_in_s) begin
                            state_r    <= ST_DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else begin
`else
                        begin
`endif
                            state_r   <= ST_REQ0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= addr0_s;
                            mem_be    <= be0_s;
                            mem_wdata <= req_we ? wd0_s : 32'h0;
                        end
                    end
                end
                ST_REQ0: begin
                    if (mem_gnt) begin
                        if (!we_r) begin
                            state_r <= ST_WAIT0;
                            mem_req <= 1'b0;
                            mem_be  <= 4'h0;
                        end else if (split_r) begin
                            state_r   <= ST_REQ1;
                            mem_addr  <= addr1_r;
                            mem_be    <= be1_r;
                            mem_wdata <= wd1_r;
                        end else begin
                            state_r    <= ST_DONE;
                            mem_req    <= 1'b0;
                            mem_we     <= 1'b0;
                            mem_be     <= 4'h0;
                            resp_valid <= 1'b1;
                            resp_rdata <= 32'h0;
                        end
                    end
                end
                ST_WAIT0: begin
                    if (mem_rvalid) begin
                        lo_r <= mem_rdata;
                        if (split_r) begin
                            state_r   <= ST_REQ1;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= addr1_r;
                            mem_be    <= be1_r;
                            mem_wdata <= 32'h0;
                        end else begin
                            state_r    <= ST_DONE;
                            resp_valid <= 1'b1;
                            resp_rdata <= ld_data_s;
                        end
                    end
                end
                ST_REQ1: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        mem_be  <= 4'h0;
                        if (!we_r) begin
                            state_r <= ST_WAIT1;
                        end else begin
                            state_r    <= ST_DONE;
                            mem_we     <= 1'b0;
                            resp_valid <= 1'b1;
                            resp_rdata <= 32'h0;
                        end
                    end
                end
                ST_WAIT1: begin
                    if (mem_rvalid) begin
                        state_r    <= ST_DONE;
                        resp_valid <= 1'b1;
                        resp_rdata <= ld_data_s;
                    end
                end
                ST_DONE: begin
                    state_r    <= ST_IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                    mem_req    <= 1'b0;
                    mem_we     <= 1'b0;
                    mem_be     <= 4'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: self-checking bench for load_store_unit.
// A byte-array reference model predicts load data, the expected sequence of
// word transactions (address, lanes, store bytes) and the fast-path latency.
// The bench also acts as the memory: random grant/rvalid delays, spurious
// rvalid while no read is outstanding, and a word array updated by stores.
module tb_load_store_unit;

    localparam int ADDR_W = 17;
    localparam int unsigned AMASK = (32'd1 << ADDR_W) - 32'd1;
    localparam int NWORDS = 1 << (ADDR_W - 2);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_sign = 1'b0;
    logic [31:0]       req_addr = 32'h0;
    logic [31:0]       req_wdata = 32'h0;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_req;
    logic              mem_gnt = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_rvalid = 1'b0;
    logic [31:0]       mem_rdata = 32'h0;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic        we;
    } txn_t;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  ref_mem [0:(1 << ADDR_W) - 1];
    logic [31:0] bmem    [0:NWORDS - 1];
    txn_t        exp_q[$];
    logic [31:0] last_rdata = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One complete access: predict, drive, act as memory, check.
    task automatic access(input logic we, input logic [1:0] size, input logic sign,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int gmin, input int gmax, input int rmax);
        int          n, lat_exp, cyc, gcnt, rcnt, nt;
        bit          rpend, waiting, done, split;
        logic [31:0] rdat, exp_rd, v;
        logic        exp_err;
        int unsigned b, w, lane;
        txn_t        t;
        txn_t        tq [2];
        logic [31:0] p_addr, p_wd;
        logic [3:0]  p_be;
        logic        p_we;

        n       = (size == 2'b00) ? 4 : ((size == 2'b01) ? 2 : 1);
        split   = ((size == 2'b00) && (addr[1:0] != 2'b00)) ||
                  ((size == 2'b01) && (addr[1:0] == 2'b11));
        exp_err = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (split) exp_err = 1'b1;
`endif
        exp_q.delete();
        nt = 0;
        v  = 32'h0;
        for (int i = 0; i < n; i++) begin
            b    = (addr + 32'(i)) & AMASK;
            w    = b & ~32'd3;
            lane = b % 4;
            if (nt == 0 || tq[nt-1].addr != w) begin
                tq[nt].addr = w;
                tq[nt].be   = 4'h0;
                tq[nt].data = 32'h0;
                tq[nt].we   = we;
                nt++;
            end
            tq[nt-1].be[lane]          = 1'b1;
            tq[nt-1].data[8*lane +: 8] = wdata[8*i +: 8];
            v[8*i +: 8] = ref_mem[b];
            if (we && !exp_err) ref_mem[b] = wdata[8*i +: 8];
        end
        if (exp_err) nt = 0;
        lat_exp = 1;
        for (int i = 0; i < nt; i++) begin
            exp_q.push_back(tq[i]);
            lat_exp += we ? 1 : 2;
        end
        if (we || exp_err)  exp_rd = 32'h0;
        else if (n == 4)    exp_rd = v;
        else if (n == 2)    exp_rd = sign ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
        else                exp_rd = sign ? {{24{v[7]}}, v[7:0]} : {24'h0, v[7:0]};

        chk("idle_ready", {31'h0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_sign = sign;
        req_addr  = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom;
        req_size  = 2'($urandom); req_sign = ~sign;

        cyc = 1; done = 0; rpend = 0; waiting = 0; rcnt = 0; rdat = 32'h0;
        p_addr = 32'h0; p_wd = 32'h0; p_be = 4'h0; p_we = 1'b0;
        gcnt = $urandom_range(gmax, gmin);
        while (!done && cyc < 80) begin
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (resp_valid) begin
                done = 1;
                last_rdata = resp_rdata;
                chk("rdata", resp_rdata, exp_rd);
                chk("resp_err", {31'h0, resp_err}, {31'h0, exp_err});
                chk("txn_left", 32'(exp_q.size()), 32'd0);
                if (gmax == 0 && rmax == 1) chk("latency", 32'(cyc), 32'(lat_exp));
            end else begin
                chk("busy_ready", {31'h0, req_ready}, 32'd0);
                if (rpend) begin
                    if (rcnt == 0) begin
                        mem_rvalid = 1'b1; mem_rdata = rdat; rpend = 0;
                    end else begin
                        rcnt--;
                    end
                end else if ($urandom_range(3, 0) == 0) begin
                    mem_rvalid = 1'b1;
                end
                if (mem_req) begin
                    if (waiting) begin
                        chk("hold_addr", 32'(mem_addr), p_addr);
                        chk("hold_be", {28'h0, mem_be}, {28'h0, p_be});
                        chk("hold_we", {31'h0, mem_we}, {31'h0, p_we});
                        chk("hold_wdata", mem_wdata, p_wd);
                    end
                    if (gcnt == 0) begin
                        mem_gnt = 1'b1; waiting = 0;
                        if (exp_q.size() == 0) begin
                            chk("extra_txn", 32'd1, 32'd0);
                        end else begin
                            t = exp_q.pop_front();
                            chk("txn_addr", 32'(mem_addr), t.addr);
                            chk("txn_be", {28'h0, mem_be}, {28'h0, t.be});
                            chk("txn_we", {31'h0, mem_we}, {31'h0, t.we});
                            for (int l = 0; l < 4; l++)
                                if (t.we && t.be[l])
                                    chk("txn_lane", {24'h0, mem_wdata[8*l +: 8]}, {24'h0, t.data[8*l +: 8]});
                        end
                        if (mem_we) begin
                            for (int l = 0; l < 4; l++)
                                if (mem_be[l]) bmem[mem_addr[ADDR_W-1:2]][8*l +: 8] = mem_wdata[8*l +: 8];
                        end else begin
                            rpend = 1;
                            rcnt  = $urandom_range(rmax, 1) - 1;
                            rdat  = bmem[mem_addr[ADDR_W-1:2]];
                        end
                        gcnt = $urandom_range(gmax, gmin);
                    end else begin
                        gcnt--; waiting = 1;
                        p_addr = 32'(mem_addr); p_be = mem_be; p_we = mem_we; p_wd = mem_wdata;
                    end
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        if (!done) chk("timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        chk("resp_pulse", {31'h0, resp_valid}, 32'd0);
        chk("ready_back", {31'h0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        for (int i = 0; i < NWORDS; i++) begin
            r = $urandom;
            bmem[i] = r;
            for (int j = 0; j < 4; j++) ref_mem[4*i + j] = r[8*j +: 8];
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'd0);
        chk("rst_mem_req", {31'h0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'd0);
        chk("rst_mem_be", {28'h0, mem_be}, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        access(1'b1, 2'b00, 1'b0, 32'h100, 32'hDEADBEEF, 0, 0, 1);
        access(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 0, 0, 1);
        chk("lw_100", last_rdata, 32'hDEADBEEF);
        access(1'b1, 2'b00, 1'b0, 32'h100, 32'h80112233, 0, 0, 1);
        access(1'b0, 2'b10, 1'b1, 32'h103, 32'h0, 0, 0, 1);
        chk("lb_103", last_rdata, 32'hFFFFFF80);
        access(1'b0, 2'b10, 1'b0, 32'h103, 32'h0, 0, 0, 1);
        chk("lbu_103", last_rdata, 32'h00000080);
        access(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 0, 0, 1);
        chk("lhu_102", last_rdata, 32'h00008011);
        access(1'b1, 2'b00, 1'b0, 32'h100, 32'h44332211, 0, 0, 1);
        access(1'b1, 2'b00, 1'b0, 32'h104, 32'h88776655, 0, 0, 1);
        access(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 0, 0, 1);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lw_102", last_rdata, 32'h0);
`else
        chk("lw_102", last_rdata, 32'h66554433);
`endif
        access(1'b1, 2'b01, 1'b0, 32'h1FFFF, 32'h0000BEEF, 0, 0, 1);
        access(1'b0, 2'b01, 1'b0, 32'h1FFFF, 32'h0, 0, 0, 1);
        access(1'b1, 2'b00, 1'b0, 32'h108, 32'hCAFEF00D, 5, 5, 1);
        access(1'b0, 2'b00, 1'b0, 32'h108, 32'h0, 5, 5, 3);
        chk("lw_108_slow", last_rdata, 32'hCAFEF00D);

        // Reset while waiting for read data; the late rvalid must be ignored.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_addr = 32'h100;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mid_req", {31'h0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'h0, mem_req}, 32'd0);
        chk("mid_rst_ready", {31'h0, req_ready}, 32'd1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_resp", {31'h0, resp_valid}, 32'd0);
            chk("post_rst_ready", {31'h0, req_ready}, 32'd1);
            chk("post_rst_mem_req", {31'h0, mem_req}, 32'd0);
            @(posedge clk); #1;
        end

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(3, 0) == 0) a = 32'h1FFF0 + $urandom_range(15, 0);
            else                           a = 32'h100 + $urandom_range(63, 0);
            a = a | ($urandom & 32'hFFFE0000);
            if (k % 3 == 0) access(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, 0, 0, 1);
            else            access(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, 0, 3, 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
